// File: rtl/sfp_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfp_ctrl_pkg : shared state encoding and address helper for sfp_acc_ctrl    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sfp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  localparam int NUM_KIJ_DEF = 9;
  // NUM_KIJ reads, one drain cycle, one write-back cycle
  localparam int CYC_PER_OUT = NUM_KIJ_DEF + 2;

  // psum SRAM is laid out kernel-position-major: row k holds all output pixels
  function automatic int unsigned psum_addr_of(input int unsigned k,
                                               input int unsigned o,
                                               input int unsigned num_out);
    return k * num_out + o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_relu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfp_relu : per-lane ReLU / pass-through selector on a packed COL-lane row   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sfp_relu
  import sfp_ctrl_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16
) (
  input  logic                     relu_en,
  input  logic [COL*PSUM_BW-1:0]   acc_in,
  output logic [COL*PSUM_BW-1:0]   acc_out
);

  for (genvar c = 0; c < COL; c++) begin : g_lane
    assign acc_out[c*PSUM_BW +: PSUM_BW] =
      (relu_en && acc_in[c*PSUM_BW + PSUM_BW - 1]) ? '0 : acc_in[c*PSUM_BW +: PSUM_BW];
  end

endmodule
`default_nettype wire

// File: rtl/sfp_acc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfp_acc_ctrl : streams NUM_KIJ psum rows per pixel into the sfp array and   |
// | writes the (optionally ReLU'd) accumulated row to output memory. Rev 1.0    |
// +----------------------------------------------------------------------------+
module sfp_acc_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int NUM_KIJ = 9,
  parameter int NUM_OUT = 16,
  parameter int ADDR_W  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     psum_rd_en,
  output logic [ADDR_W-1:0]        psum_addr,
  input  logic [COL*PSUM_BW-1:0]   psum_rdata,
  output logic                     sfp_valid,
  output logic                     sfp_clear,
  output logic [COL*PSUM_BW-1:0]   sfp_in,
  input  logic [COL*PSUM_BW-1:0]   sfp_acc,
  output logic                     out_wr_en,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [COL*PSUM_BW-1:0]   out_wdata
);

  localparam int K_W = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;
  localparam int O_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [K_W-1:0] C_K_LAST = K_W'(NUM_KIJ - 1);
  localparam logic [O_W-1:0] C_O_LAST = O_W'(NUM_OUT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [K_W-1:0]          r_k_cnt;
  logic [O_W-1:0]          r_o_cnt;
  logic                    r_relu;
  logic                    r_sfp_valid;
  logic [COL*PSUM_BW-1:0]  w_relu_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_k_cnt     <= '0;
      r_o_cnt     <= '0;
      r_relu      <= 1'b0;
      r_sfp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // read data lands one cycle after the strobe, so valid follows it
      r_sfp_valid <= psum_rd_en;
      case (r_state)
        ST_IDLE:  if (start) r_relu <= relu_en;
        ST_CLEAR: begin
          r_k_cnt <= '0;
          r_o_cnt <= '0;
        end
        ST_READ:  r_k_cnt <= r_k_cnt + 1'b1;
        ST_WB: begin
          if (r_o_cnt != C_O_LAST) begin
            r_o_cnt <= r_o_cnt + 1'b1;
            r_k_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    psum_rd_en  = 1'b0;
    psum_addr   = '0;
    sfp_clear   = 1'b0;
    out_wr_en   = 1'b0;
    out_addr    = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy        = 1'b1;
        sfp_clear   = 1'b1;
        w_state_nxt = ST_READ;
      end
      ST_READ: begin
        busy       = 1'b1;
        psum_rd_en = 1'b1;
        psum_addr  = ADDR_W'(psum_addr_of(32'(r_k_cnt), 32'(r_o_cnt), NUM_OUT));
        if (r_k_cnt == C_K_LAST) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        // sum is sampled here; the clear only lands at the closing edge
        busy        = 1'b1;
        out_wr_en   = 1'b1;
        sfp_clear   = 1'b1;
        out_addr    = ADDR_W'(r_o_cnt);
        w_state_nxt = (r_o_cnt == C_O_LAST) ? ST_FIN : ST_READ;
      end
      ST_FIN: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  sfp_relu #(
    .COL     (COL),
    .PSUM_BW (PSUM_BW)
  ) u_relu (
    .relu_en (r_relu),
    .acc_in  (sfp_acc),
    .acc_out (w_relu_out)
  );

  assign sfp_valid = r_sfp_valid;
  assign sfp_in    = psum_rdata;
  assign out_wdata = (r_state == ST_WB) ? w_relu_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_sfp_acc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sfp_acc_ctrl : directed bench with psum SRAM and sfp accumulator models  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sfp_acc_ctrl;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int NUM_KIJ = 9;
  localparam int NUM_OUT = 16;
  localparam int ADDR_W  = 11;
  localparam int W       = COL * PSUM_BW;

  logic              clk;
  logic              reset;
  logic              start;
  logic              relu_en;
  logic              busy;
  logic              done;
  logic              psum_rd_en;
  logic [ADDR_W-1:0] psum_addr;
  logic [W-1:0]      psum_rdata;
  logic              sfp_valid;
  logic              sfp_clear;
  logic [W-1:0]      sfp_in;
  logic [W-1:0]      sfp_acc;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic [W-1:0]      out_wdata;

  sfp_acc_ctrl #(
    .COL(COL), .PSUM_BW(PSUM_BW), .NUM_KIJ(NUM_KIJ), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done),
    .psum_rd_en(psum_rd_en), .psum_addr(psum_addr), .psum_rdata(psum_rdata),
    .sfp_valid(sfp_valid), .sfp_clear(sfp_clear), .sfp_in(sfp_in), .sfp_acc(sfp_acc),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_wdata(out_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment: psum SRAM (1-cycle read) and the sfp accumulator lanes
  logic [W-1:0] mem [0:2047];
  always_ff @(posedge clk) if (psum_rd_en) psum_rdata <= mem[psum_addr];

  always_ff @(posedge clk) begin
    for (int c = 0; c < COL; c++) begin
      if (reset || sfp_clear)  sfp_acc[c*PSUM_BW +: PSUM_BW] <= '0;
      else if (sfp_valid)      sfp_acc[c*PSUM_BW +: PSUM_BW] <= sfp_acc[c*PSUM_BW +: PSUM_BW] + sfp_in[c*PSUM_BW +: PSUM_BW];
    end
  end

  logic [W-1:0]      cap [0:NUM_OUT-1];
  logic [ADDR_W-1:0] rd_log [0:4095];
  int wr_cnt = 0, done_cnt = 0, rd_n = 0, viol = 0;
  always @(posedge clk) begin
    if (out_wr_en) begin cap[out_addr[3:0]] = out_wdata; wr_cnt++; end
    if (done) done_cnt++;
    if (psum_rd_en && rd_n < 4096) begin rd_log[rd_n] = psum_addr; rd_n++; end
    if ((out_wr_en && psum_rd_en) || (sfp_valid && sfp_clear)) viol++;
  end

  int n_assert = 0, n_fail = 0;
  int wr_base, done_base, rd_base, cyc, errs;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    logic [PSUM_BW-1:0] v;
    for (int k = 0; k < NUM_KIJ; k++)
      for (int o = 0; o < NUM_OUT; o++)
        for (int c = 0; c < COL; c++) begin
          case (mode)
            0: v = 16'd1;
            1: v = 16'(k + o + c);
            2: v = 16'hFFFD;
            3: v = (c % 2 == 0) ? 16'hFFFD : 16'd2;
            default: v = 16'h7000;
          endcase
          mem[k*NUM_OUT + o][c*PSUM_BW +: PSUM_BW] = v;
        end
  endtask

  function automatic logic [PSUM_BW-1:0] exp_lane(input int mode, input bit relu, input int o, input int c);
    case (mode)
      0: return 16'd9;
      1: return 16'(36 + 9*o + 9*c);
      2: return relu ? 16'h0000 : 16'hFFE5;
      3: return (c % 2 == 0) ? (relu ? 16'h0000 : 16'hFFE5) : 16'd18;
      default: return 16'hF000;
    endcase
  endfunction

  task automatic check_outs(input string tag, input int mode, input bit relu);
    logic [W-1:0] row;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int c = 0; c < COL; c++) row[c*PSUM_BW +: PSUM_BW] = exp_lane(mode, relu, o, c);
      chk($sformatf("%s_out%0d", tag, o), cap[o], row);
    end
  endtask

  task automatic kick(input logic relu);
    @(negedge clk); start = 1'b1; relu_en = relu;
    @(negedge clk); start = 1'b0;
  endtask

  // called in cycle 1 (CLEAR); returns the cycle index where done is seen
  task automatic wait_done(input int pulse_cyc, input bit toggle, output int c_out);
    int c = 1;
    while (!done && c < 400) begin
      @(negedge clk); c++;
      start = (c == pulse_cyc);
      if (toggle) relu_en = ~relu_en;
    end
    c_out = done ? c : -1;
  endtask

  task automatic run_std(input string tag, input int mode, input bit relu, input int pulse_cyc, input bit toggle);
    fill(mode);
    wr_base = wr_cnt; done_base = done_cnt; rd_base = rd_n;
    kick(relu);
    chk({tag, "_clear"}, {127'd0, sfp_clear}, 1);
    wait_done(pulse_cyc, toggle, cyc);
    chk({tag, "_done_cycle"}, cyc, 178);
    chk({tag, "_busy_fin"}, {127'd0, busy}, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {127'd0, done}, 0);
    chk({tag, "_writes"}, wr_cnt - wr_base, 16);
    chk({tag, "_dones"}, done_cnt - done_base, 1);
    check_outs(tag, mode, relu);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; relu_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {127'd0, busy}, 0);
    chk("rst_done", {127'd0, done}, 0);
    chk("rst_rd_en", {127'd0, psum_rd_en}, 0);
    chk("rst_wr_en", {127'd0, out_wr_en}, 0);
    chk("rst_valid", {127'd0, sfp_valid}, 0);
    chk("rst_clear", {127'd0, sfp_clear}, 0);
    chk("rst_addrs", {psum_addr, out_addr}, 0);
    chk("rst_wdata", out_wdata, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {127'd0, busy}, 0);

    run_std("ones", 0, 1'b0, 0, 1'b0);

    run_std("ramp", 1, 1'b0, 0, 1'b0);
    chk("ramp_reads", rd_n - rd_base, 144);
    errs = 0;
    for (int i = 0; i < 144; i++)
      if (rd_log[rd_base + i] !== ADDR_W'((i % 9) * 16 + i / 9)) errs++;
    chk("ramp_rd_addr_seq", errs, 0);

    run_std("neg_relu", 2, 1'b1, 0, 1'b0);
    run_std("neg_norelu", 2, 1'b0, 0, 1'b0);
    run_std("mixed_relu", 3, 1'b1, 0, 1'b0);
    // restart pulse in READ of output 5 and relu_en toggling every cycle
    run_std("restart_ign", 3, 1'b0, 60, 1'b1);

    // abort with reset in READ of output 3, k=4 (cycle 39)
    fill(1);
    wr_base = wr_cnt; done_base = done_cnt;
    kick(1'b0);
    repeat (38) @(negedge clk);
    chk("abort_rd_en", {127'd0, psum_rd_en}, 1);
    chk("abort_addr", psum_addr, 67);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {127'd0, busy}, 0);
    chk("abort_strobes", {psum_rd_en, out_wr_en, sfp_valid, sfp_clear, done}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - done_base, 0);
    chk("abort_writes", wr_cnt - wr_base, 3);
    run_std("after_abort", 1, 1'b0, 0, 1'b0);

    // back-to-back with wrap-around data
    fill(4);
    wr_base = wr_cnt; done_base = done_cnt;
    kick(1'b0);
    wait_done(0, 1'b0, cyc);
    chk("b2b_first_done", cyc, 178);
    start = 1'b1;
    @(negedge clk);
    chk("b2b_start_in_fin_ignored", {127'd0, busy}, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_clear", {126'd0, busy, sfp_clear}, 3);
    wait_done(0, 1'b0, cyc);
    chk("b2b_second_done", cyc, 178);
    @(negedge clk);
    chk("b2b_writes", wr_cnt - wr_base, 32);
    chk("b2b_dones", done_cnt - done_base, 2);
    check_outs("wrap", 4, 1'b0);

    chk("strobe_exclusive", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
